mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4:1 single-bit multiplexer datapath (data X[3:0], select C[1:0], output Y).
- Four requesters contend for the mux output; the block grants one owner at a time and drives the mux select from the grant.
- Also gates the muxed bit with a valid flag.
- Sits between the requesters and the dataflow mux; the mux itself is instantiated unchanged inside this block.

Parameters:
- MAX_HOLD, 8: maximum consecutive GRANT cycles for one owner while others wait. Legal range 2..255. Used only when the optional feature is compiled in.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- REQ  input  4  per-requester request; level, held high while the requester wants or uses the mux.
- X  input  4  mux data inputs; X[i] belongs to requester i.
- GNT  output  4  one-hot grant, registered.
- C  output  2  registered mux select = index of current or last owner.
- VALID  output  1  registered; high only in GRANT state.
- Y  output  1  combinational: X[C] when VALID=1, else 0.

Behaviour:
- Reset (async, immediate, also mid-grant): state=IDLE, GNT=0000, C=00, VALID=0, round-robin pointer PTR=0, hold counter=0. Y=0 follows.
- State machine, all transitions on rising clk:
  - IDLE: if REQ!=0, pick the first set REQ bit scanning PTR, PTR+1, ... mod 4. Go to GRANT. GNT=onehot(winner), C=winner, VALID=1, PTR=winner+1 mod 4 (3 wraps to 0). If REQ=0, stay in IDLE with outputs unchanged except VALID=0 and GNT=0.
  - GRANT: stay while REQ[C]=1 (and no timeout, see optional feature). When REQ[C]=0 is sampled, go to TURN.
  - TURN: exactly one cycle with GNT=0000 and VALID=0; C keeps the last owner. Always goes to IDLE.
- Latency: a request first sampled high in IDLE produces GNT/VALID high after that same edge, i.e. 1 cycle. Owner drop to next grant takes 3 edges (GRANT->TURN->IDLE->GRANT). The mandatory TURN bubble prevents back-to-back ownership glitches on Y.
- Other requesters' REQ changes during GRANT are ignored until re-arbitration.
- Owner re-raises REQ during TURN: arbitrated normally in IDLE. PTR has already advanced past it, so it loses to any other pending requester.
- Single requester repeatedly requesting: always wins; still passes through TURN each time.
- Invariants: GNT is zero or one-hot. GNT!=0 iff VALID=1. When VALID=1, C equals the index of the set GNT bit.
- Y is purely combinational from X, C and VALID; no clock delay.

Optional Feature:
- Macro: MUX4_ARB_HOLD_TIMEOUT_EN.
- Defined:
  - Hold counter clears on entry to GRANT and increments each GRANT cycle, saturating at MAX_HOLD-1.
  - If the counter equals MAX_HOLD-1 and any REQ bit other than REQ[C] is high, go to TURN even though REQ[C]=1. The owner is pre-empted after exactly MAX_HOLD VALID cycles.
  - With no other requesters, the owner keeps the grant indefinitely.
  - Owner dropping REQ in the same cycle as the timeout is a normal release; the result is identical.
- Undefined: no counter logic; GRANT is left only by the owner dropping REQ; MAX_HOLD has no effect.

Test Plan:
- Reset mid-grant: REQ=0001, wait 3 cycles, pulse reset between edges -> GNT=0000, C=00, VALID=0, Y=0 immediately, before the next edge.
- Basic grant/mux: reset, REQ=0100, X=0100 -> after 1 edge GNT=0100, C=10, VALID=1, Y=1. X=0000 -> Y=0 with no clock.
- Round-robin fairness: REQ=1111, each owner holds 2 cycles then drops and re-raises -> grant order 0,1,2,3,0, with one TURN cycle (VALID=0) between each.
- Pointer wrap: grant 3, then REQ=1001 -> next grant index 0 (C=00), not 3.
- Timeout, macro defined, MAX_HOLD=4: REQ=0011 held high -> owner 0 gets VALID for exactly 4 cycles, TURN, then owner 1 gets 4 cycles. With the macro undefined -> owner 0 holds indefinitely.
- Lone owner under timeout: macro defined, REQ=0010 for 20 cycles -> GNT=0010 continuously, no TURN.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer in front of a 4:1 single-bit mux.
// Optional owner hold timeout: define MUX4_ARB_HOLD_TIMEOUT_EN.

module mux4_dataflow (
  input  logic [3:0] x,
  input  logic [1:0] c,
  output logic       y
);

  assign y = (x[0] & ~c[1] & ~c[0])
           | (x[1] & ~c[1] &  c[0])
           | (x[2] &  c[1] & ~c[0])
           | (x[3] &  c[1] &  c[0]);

endmodule

module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] REQ,
  input  logic [3:0] X,
  output logic [3:0] GNT,
  output logic [1:0] C,
  output logic       VALID,
  output logic       Y
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range 2..255");
  end

  state_t     state;
  state_t     state_n;
  logic [3:0] gnt_n;
  logic [1:0] c_n;
  logic       valid_n;
  logic [1:0] ptr;
  logic [1:0] ptr_n;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       expire;
  logic       mux_y;

  // First set request scanning upward from the pointer, wrapping at 3.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef MUX4_ARB_HOLD_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold;
  logic [7:0] hold_n;
  logic       others;

  assign others = |(REQ & ~GNT);
  assign expire = (hold == HOLD_LAST) && others;

  always_comb begin
    hold_n = '0;
    if (state == GRANT) begin
      hold_n = (hold == HOLD_LAST) ? hold : hold + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold <= '0;
    end else begin
      hold <= hold_n;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_n = state;
    gnt_n   = GNT;
    c_n     = C;
    valid_n = VALID;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = 4'(1) << win;
          c_n     = win;
          valid_n = 1'b1;
          ptr_n   = win + 2'd1;
        end else begin
          gnt_n   = '0;
          valid_n = 1'b0;
        end
      end
      GRANT: begin
        if (!REQ[C] || expire) begin
          state_n = TURN;
          gnt_n   = '0;
          valid_n = 1'b0;
        end
      end
      TURN: begin
        state_n = IDLE;
        gnt_n   = '0;
        valid_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      GNT   <= '0;
      C     <= '0;
      VALID <= 1'b0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      GNT   <= gnt_n;
      C     <= c_n;
      VALID <= valid_n;
      ptr   <= ptr_n;
    end
  end

  mux4_dataflow u_mux (
    .x (X),
    .c (C),
    .y (mux_y)
  );

  assign Y = VALID & mux_y;

endmodule
